// File: rtl/mips_dbg_pkg.sv
// mips_dbg_pkg: shared types and constants for the register-file debug readback slice
package mips_dbg_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, HOLD, DONE} state_t;
  localparam int REG_COUNT = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/dump_out_reg.sv
// dump_out_reg: output holding register for the dump stream with valid/ready hold
module dump_out_reg import mips_dbg_pkg::*; #(
  parameter int DW = DATA_W,
  parameter int AW = REG_ADDR_W
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic          flush,
  input  logic          dump_ready,
  input  logic [DW-1:0] d_data,
  input  logic [AW-1:0] d_idx,
  input  logic          d_last,
  output logic          dump_valid,
  output logic [DW-1:0] dump_data,
  output logic [AW-1:0] dump_idx,
  output logic          dump_last
);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_idx   <= '0;
      dump_last  <= 1'b0;
    end else if (load) begin
      dump_valid <= 1'b1;
      dump_data  <= d_data;
      dump_idx   <= d_idx;
      dump_last  <= d_last;
    end else if (flush || (dump_valid && dump_ready)) begin
      dump_valid <= 1'b0;
    end
endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks the register file, streams each word with its index, flags stale dumps
module reg_dump_reader import mips_dbg_pkg::*; #(
  parameter int DATA_W    = mips_dbg_pkg::DATA_W,
  parameter int ADDR_W    = REG_ADDR_W,
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = REG_COUNT - 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              rf_wr_en,
  input  logic [ADDR_W-1:0] rf_wr_addr,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [ADDR_W-1:0] dump_idx,
  output logic              dump_last,
  output logic              busy,
  output logic              done,
  output logic              stale
);
  localparam logic [ADDR_W-1:0] FIRST_A = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(LAST_REG);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic stale_nxt, hit;
  assign rf_addr = ptr;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  assign hit     = busy && rf_wr_en && rf_wr_addr != ADDR_W'(REG_ZERO)
                   && int'(rf_wr_addr) >= FIRST_REG && rf_wr_addr <= ptr;
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    stale_nxt = stale | hit;
    unique case (state)
      IDLE: if (start && !abort) begin
        state_nxt = CAPTURE;
        ptr_nxt   = FIRST_A;
        stale_nxt = 1'b0;
      end
      CAPTURE: state_nxt = abort ? IDLE : HOLD;
      HOLD: if (abort) state_nxt = IDLE;
      else if (dump_valid && dump_ready) begin
        state_nxt = dump_last ? DONE : CAPTURE;
        ptr_nxt   = dump_last ? ptr : ptr + 1'b1;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      ptr   <= FIRST_A;
      stale <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      stale <= stale_nxt;
    end
  dump_out_reg #(.DW(DATA_W), .AW(ADDR_W)) u_out (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (state == CAPTURE && !abort),
    .flush      (abort),
    .dump_ready (dump_ready),
    .d_data     (rf_data),
    .d_idx      (ptr),
    .d_last     (ptr == LAST_A),
    .dump_valid (dump_valid),
    .dump_data  (dump_data),
    .dump_idx   (dump_idx),
    .dump_last  (dump_last)
  );
endmodule
